// File: rtl/ref_clk_out.sv
// Reference clock generator: a DIV-cycle output period with HIGH cycles high, clean
// enable/disable that never truncates a period, phase resync, and a completed-period counter.
module ref_clk_out #(
    parameter int unsigned DIV   = 25,
    parameter int unsigned HIGH  = 12,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sync_req,
    input  logic             count_clear,
    output logic             ref_out,
    output logic             ref_oe,
    output logic             sync_done,
    output logic [CNT_W-1:0] period_count
);

    localparam int unsigned   PW     = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST   = PW'(DIV - 1);
    localparam logic [PW-1:0] HIGH_P = PW'(HIGH);

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    state_e           r_state, w_state_d;
    logic [PW-1:0]    r_cnt, w_cnt_d;
    logic             r_pend, w_pend_d;
    logic             r_ref_out, r_ref_oe;
    logic [CNT_W-1:0] r_period, w_period_d;

    logic             w_at_last;
    logic             w_apply;
    logic             w_period_inc;
    logic             w_ref_out_d;
    logic             w_ref_oe_d;
    logic [PW-1:0]    w_cnt_step;

    assign w_at_last  = (r_cnt == LAST);
    assign w_cnt_step = w_at_last ? '0 : r_cnt + PW'(1);

    // A sync lands only in the low phase, so it can shorten low but never high.
    assign w_apply = (r_state == StRun) && (r_pend || sync_req) && (r_cnt >= HIGH_P);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_pend    <= 1'b0;
            r_ref_out <= 1'b0;
            r_ref_oe  <= 1'b0;
            r_period  <= '0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_pend    <= w_pend_d;
            r_ref_out <= w_ref_out_d;
            r_ref_oe  <= w_ref_oe_d;
            r_period  <= w_period_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_pend_d  = r_pend;
        unique case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                if (sync_req) begin
                    w_pend_d = 1'b0;
                end
                if (enable) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                w_cnt_d  = w_apply ? '0 : w_cnt_step;
                w_pend_d = w_apply ? 1'b0 : (r_pend | sync_req);
                if (!enable) begin
                    w_state_d = StStop;
                end
            end
            StStop: begin
                w_cnt_d = w_cnt_step;
                if (sync_req) begin
                    w_pend_d = 1'b0;
                end
                // Leave only at the end of a full period so the last pulse is never cut.
                if (enable) begin
                    w_state_d = StRun;
                end else if (w_at_last) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
                w_pend_d  = 1'b0;
            end
        endcase
    end

    // Output logic: flops are loaded from next-state values for zero extra latency
    always_comb begin
        w_ref_oe_d   = (w_state_d != StIdle);
        w_ref_out_d  = w_ref_oe_d && (w_cnt_d < HIGH_P);
        w_period_inc = ((r_state != StIdle) && w_at_last) || w_apply;
        if (count_clear) begin
            w_period_d = '0;
        end else begin
            w_period_d = r_period + CNT_W'(w_period_inc);
        end
    end

    assign ref_out      = r_ref_out;
    assign ref_oe       = r_ref_oe;
    assign sync_done    = w_apply;
    assign period_count = r_period;

endmodule

// File: tb/tb_ref_clk_out.sv
// Bench for ref_clk_out: directed scenarios with literal expectations, then random
// enable/sync/clear/reset traffic, all compared every cycle against a period-level model.
module tb_ref_clk_out;

    localparam int DIV  = 25;
    localparam int HIGH = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        sync_req;
    logic        count_clear;
    logic        ref_out;
    logic        ref_oe;
    logic        sync_done;
    logic [31:0] period_count;
    logic        ref4;
    logic        oe4;
    logic        sd4;
    logic [7:0]  pc4;

    always #2 clk = ~clk;

    ref_clk_out dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sync_req    (sync_req),
        .count_clear (count_clear),
        .ref_out     (ref_out),
        .ref_oe      (ref_oe),
        .sync_done   (sync_done),
        .period_count(period_count)
    );

    ref_clk_out #(.DIV(4), .HIGH(1), .CNT_W(8)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (1'b1),
        .sync_req    (1'b0),
        .count_clear (1'b0),
        .ref_out     (ref4),
        .ref_oe      (oe4),
        .sync_done   (sd4),
        .period_count(pc4)
    );

    int          vectors     = 0;
    int          miscompares = 0;

    // Model: mode 0 = off, 1 = running, 2 = finishing the current period.
    int          m_mode;
    int          m_pos;
    bit          m_pend;
    logic [31:0] m_count;
    int          k4;
    logic        tb_sd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_apply(input bit sr);
        return (m_mode == 1) && (m_pend || sr) && (m_pos >= HIGH);
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_pos   = 0;
        m_pend  = 1'b0;
        m_count = '0;
        k4      = 0;
    endtask

    task automatic model_step(input bit en, input bit sr, input bit cc);
        bit ap;
        bit wr;
        ap = m_apply(sr);
        wr = (m_mode != 0) && (m_pos == DIV - 1);
        m_count = cc ? 32'd0 : m_count + ((ap || wr) ? 32'd1 : 32'd0);
        case (m_mode)
            0: begin
                if (sr) m_pend = 1'b0;
                m_pos  = 0;
                m_mode = en ? 1 : 0;
            end
            1: begin
                m_pend = ap ? 1'b0 : (m_pend | sr);
                m_pos  = ap ? 0 : (m_pos + 1) % DIV;
                m_mode = en ? 1 : 2;
            end
            default: begin
                if (sr) m_pend = 1'b0;
                m_pos  = (m_pos + 1) % DIV;
                m_mode = en ? 1 : (wr ? 0 : 2);
            end
        endcase
    endtask

    // One clock cycle: drive inputs, compare every output against the model, advance.
    task automatic cyc(input bit en, input bit sr, input bit cc);
        @(negedge clk);
        enable      = en;
        sync_req    = sr;
        count_clear = cc;
        #1;
        check("ref_out", 32'(ref_out), 32'(m_mode != 0 && m_pos < HIGH));
        check("ref_oe", 32'(ref_oe), 32'(m_mode != 0));
        check("sync_done", 32'(sync_done), 32'(m_apply(sr)));
        check("period_count", period_count, m_count);
        check("div4_ref_out", 32'(ref4), 32'(k4 >= 1 && (k4 - 1) % 4 == 0));
        tb_sd = sync_done;
        @(posedge clk);
        model_step(en, sr, cc);
        k4++;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        enable      = 1'b0;
        sync_req    = 1'b0;
        count_clear = 1'b0;
        #1;
        check("rst_ref_out", 32'(ref_out), 32'd0);
        check("rst_ref_oe", 32'(ref_oe), 32'd0);
        check("rst_period_count", period_count, 32'd0);
        check("rst_div4_ref_out", 32'(ref4), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit en_r;
        rst_n       = 1'b0;
        enable      = 1'b0;
        sync_req    = 1'b0;
        count_clear = 1'b0;
        tb_sd       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("init_ref_out", 32'(ref_out), 32'd0);
        check("init_ref_oe", 32'(ref_oe), 32'd0);
        check("init_period_count", period_count, 32'd0);

        // Enable at cycle 0: output up at cycle 1, four periods completed after cycle 100.
        cyc(1, 0, 0);
        check("c1_ref_out", 32'(ref_out), 32'd1);
        check("c1_ref_oe", 32'(ref_oe), 32'd1);
        repeat (100) cyc(1, 0, 0);
        check("c101_period_count", period_count, 32'd4);
        check("c101_ref_out", 32'(ref_out), 32'd1);

        // Sync requested at cnt=3 lands at cnt=12, giving a one-cycle low phase.
        repeat (3) cyc(1, 0, 0);
        cyc(1, 1, 0);
        repeat (8) cyc(1, 0, 0);
        check("sync_pending_no_done", 32'(tb_sd), 32'd0);
        cyc(1, 0, 0);
        check("sync_done_cnt12", 32'(tb_sd), 32'd1);
        check("sync_rise_ref_out", 32'(ref_out), 32'd1);
        check("sync_period_count", period_count, 32'd5);

        // Disable at cnt=5: full high and low phases finish, then the driver turns off.
        repeat (5) cyc(1, 0, 0);
        repeat (20) cyc(0, 0, 0);
        check("stop_ref_oe", 32'(ref_oe), 32'd0);
        check("stop_ref_out", 32'(ref_out), 32'd0);
        check("stop_period_count", period_count, 32'd6);

        // Sync at cnt=20 applies in the same cycle.
        repeat (21) cyc(1, 0, 0);
        cyc(1, 1, 0);
        check("sync20_done", 32'(tb_sd), 32'd1);
        check("sync20_ref_out", 32'(ref_out), 32'd1);
        check("sync20_period_count", period_count, 32'd7);

        // Reset at cnt=6 while the output is high.
        repeat (6) cyc(1, 0, 0);
        check("pre_reset_ref_out", 32'(ref_out), 32'd1);
        do_reset();

        // Enable dropped at cnt=2 and restored at cnt=10: the driver never turns off.
        cyc(1, 0, 0);
        repeat (2) cyc(1, 0, 0);
        repeat (8) cyc(0, 0, 0);
        check("bounce_ref_oe", 32'(ref_oe), 32'd1);
        check("bounce_ref_out", 32'(ref_out), 32'd1);
        repeat (30) cyc(1, 0, 0);
        check("bounce_ref_oe_after", 32'(ref_oe), 32'd1);

        // Random traffic, including sync requests while stopping and idle.
        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 39) == 0) en_r = ~en_r;
                cyc(en_r, $urandom_range(0, 14) == 0, $urandom_range(0, 99) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
